// File: rtl/uart_receive_if.sv
// ============================================================================
//  Module   : uart_receive_if
//  Purpose  : CPU bus view of the UART receiver. Carries the chip-select and
//             read decode inputs, and returns the received byte and status
//             flags.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface uart_receive_if;
  logic       iocs;
  logic       iorw;
  logic [1:0] ioaddr;
  logic [7:0] rx_data;
  logic       rda;
  logic       framing_err;
  logic       overrun_err;
  logic       parity_err;

  // CPU side: issues bus cycles and observes the receiver
  modport master (
    output iocs, iorw, ioaddr,
    input  rx_data, rda, framing_err, overrun_err, parity_err
  );

  // Receiver side: decodes bus cycles and presents data and status
  modport slave (
    input  iocs, iorw, ioaddr,
    output rx_data, rda, framing_err, overrun_err, parity_err
  );
endinterface

`default_nettype wire

// File: rtl/uart_receive.sv
// ============================================================================
//  Module   : uart_receive
//  Purpose  : UART receiver. Deserialises an idle-high, LSB-first frame
//             (start, 8 data bits, optional even parity, stop) from rxd
//             using an oversampled baud enable. Holds the byte for the CPU
//             and keeps sticky framing, overrun and parity error flags.
//  Options  : UART_RX_PARITY_EN - when defined, adds one even-parity bit
//             between the data and stop bits. When undefined, the frame is
//             10 bits long and parity_err reads as 0.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_receive #(
  parameter int OVERSAMPLE = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         brg_en,
  input  logic         rxd,
  uart_receive_if.slave bus
);

  localparam int                c_tick_w    = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [c_tick_w-1:0] c_tick_last = c_tick_w'(OVERSAMPLE - 1);
  localparam logic [c_tick_w-1:0] c_tick_half = c_tick_w'(OVERSAMPLE / 2 - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  state_t              r_state;
  logic [c_tick_w-1:0] r_tick;
  logic [2:0]          r_bit_cnt;
  logic [7:0]          r_shift;
  logic                r_rxd_meta;
  logic                r_rxd_s;
  logic [7:0]          r_rx_data;
  logic                r_rda;
  logic                r_framing_err;
  logic                r_overrun_err;

  // Bus reads take effect at the clock edge; writes are ignored.
  logic w_rd_data;
  logic w_rd_stat;
  assign w_rd_data = bus.iocs & bus.iorw & (bus.ioaddr == 2'd0);
  assign w_rd_stat = bus.iocs & bus.iorw & (bus.ioaddr == 2'd1);

`ifdef UART_RX_PARITY_EN
  logic r_parity_err;
`endif

  // Synchroniser, receive FSM, and flag set/clear. Later assignments in this
  // block override the bus clears, so a flag being set in the same cycle as
  // a read wins.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state       <= ST_IDLE;
      r_tick        <= '0;
      r_bit_cnt     <= '0;
      r_shift       <= '0;
      r_rxd_meta    <= 1'b1;
      r_rxd_s       <= 1'b1;
      r_rx_data     <= '0;
      r_rda         <= 1'b0;
      r_framing_err <= 1'b0;
      r_overrun_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_parity_err  <= 1'b0;
`endif
    end else begin
      r_rxd_meta <= rxd;
      r_rxd_s    <= r_rxd_meta;

      if (w_rd_data) begin
        r_rda <= 1'b0;
      end
      if (w_rd_stat) begin
        r_framing_err <= 1'b0;
        r_overrun_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
        r_parity_err  <= 1'b0;
`endif
      end

      if (brg_en) begin
        case (r_state)
          ST_IDLE: begin
            if (!r_rxd_s) begin
              r_state <= ST_START;
              r_tick  <= '0;
            end
          end

          // Re-check the line half a bit later to reject glitches.
          ST_START: begin
            if (r_tick == c_tick_half) begin
              if (!r_rxd_s) begin
                r_state   <= ST_DATA;
                r_tick    <= '0;
                r_bit_cnt <= '0;
              end else begin
                r_state <= ST_IDLE;
              end
            end else begin
              r_tick <= r_tick + 1'b1;
            end
          end

          // Sample mid-bit; right shift so bit 0 ends up in r_shift[0].
          ST_DATA: begin
            if (r_tick == c_tick_last) begin
              r_tick    <= '0;
              r_shift   <= {r_rxd_s, r_shift[7:1]};
              r_bit_cnt <= r_bit_cnt + 1'b1;
              if (r_bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                r_state <= ST_PARITY;
`else
                r_state <= ST_STOP;
`endif
              end
            end else begin
              r_tick <= r_tick + 1'b1;
            end
          end

`ifdef UART_RX_PARITY_EN
          // Even parity: the parity bit equals the XOR of the data bits.
          ST_PARITY: begin
            if (r_tick == c_tick_last) begin
              r_tick  <= '0;
              r_state <= ST_STOP;
              if (r_rxd_s != ^r_shift) begin
                r_parity_err <= 1'b1;
              end
            end else begin
              r_tick <= r_tick + 1'b1;
            end
          end
`endif

          // Good stop delivers the byte; a read in this same cycle keeps rda
          // set and is not an overrun.
          ST_STOP: begin
            if (r_tick == c_tick_last) begin
              r_tick  <= '0;
              r_state <= ST_IDLE;
              if (r_rxd_s) begin
                r_rx_data <= r_shift;
                r_rda     <= 1'b1;
                if (r_rda && !w_rd_data) begin
                  r_overrun_err <= 1'b1;
                end
              end else begin
                r_framing_err <= 1'b1;
              end
            end else begin
              r_tick <= r_tick + 1'b1;
            end
          end

          default: begin
            r_state <= ST_IDLE;
            r_tick  <= '0;
          end
        endcase
      end
    end
  end

  assign bus.rx_data     = r_rx_data;
  assign bus.rda         = r_rda;
  assign bus.framing_err = r_framing_err;
  assign bus.overrun_err = r_overrun_err;
`ifdef UART_RX_PARITY_EN
  assign bus.parity_err  = r_parity_err;
`else
  assign bus.parity_err  = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_uart_receive.sv
// ============================================================================
//  Module   : tb_uart_receive
//  Purpose  : Directed self-checking bench for uart_receive. brg_en is held
//             high, so one bit period is 16 clock cycles.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_receive;

`ifdef UART_RX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int OS = 16;
  // Clock index within a frame at which the stop bit is sampled (byte completes).
  localparam int DONE_CYCLE = 2 + OS / 2 + OS * (NBITS - 1);

  logic clk;
  logic rst;
  logic brg_en;
  logic rxd;
  int   n_checks;
  int   n_fail;

  uart_receive_if bus ();

  uart_receive #(.OVERSAMPLE(OS)) dut (
    .clk    (clk),
    .rst    (rst),
    .brg_en (brg_en),
    .rxd    (rxd),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Build a frame LSB-first: start, data, [parity], stop.
  function automatic logic [10:0] make_frame(input logic [7:0] d, input logic stop_bit,
                                             input logic bad_par);
    logic [10:0] f;
    f = 11'h7FF;
    f[0] = 1'b0;
    f[8:1] = d;
`ifdef UART_RX_PARITY_EN
    f[9]  = (^d) ^ bad_par;
    f[10] = stop_bit;
`else
    f[9]  = stop_bit ^ (bad_par & 1'b0);
`endif
    return f;
  endfunction

  // Drive one frame; a data read is pulsed on clock index rd_cycle (-1 = none).
  task automatic send_frame(input logic [10:0] f, input int rd_cycle);
    for (int c = 0; c < NBITS * OS; c++) begin
      @(negedge clk);
      rxd        = f[c / OS];
      bus.iocs   = (c == rd_cycle);
      bus.iorw   = 1'b1;
      bus.ioaddr = 2'd0;
    end
    @(negedge clk);
    rxd      = 1'b1;
    bus.iocs = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One-cycle bus access; returns at the negedge after the acting edge.
  task automatic bus_cycle(input logic rw, input logic [1:0] addr);
    @(negedge clk);
    bus.iocs   = 1'b1;
    bus.iorw   = rw;
    bus.ioaddr = addr;
    @(negedge clk);
    bus.iocs   = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    rxd = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (bus.rx_data !== 8'h00) begin n_fail++; $display("FAIL reset_rx_data got %h exp 00", bus.rx_data); end
    n_checks++; if (bus.rda !== 1'b0) begin n_fail++; $display("FAIL reset_rda got %b exp 0", bus.rda); end
    n_checks++; if (bus.framing_err !== 1'b0) begin n_fail++; $display("FAIL reset_fe got %b exp 0", bus.framing_err); end
    n_checks++; if (bus.overrun_err !== 1'b0) begin n_fail++; $display("FAIL reset_oe got %b exp 0", bus.overrun_err); end
    n_checks++; if (bus.parity_err !== 1'b0) begin n_fail++; $display("FAIL reset_pe got %b exp 0", bus.parity_err); end
    rxd = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    idle(40);
    n_checks++; if (bus.rda !== 1'b0) begin n_fail++; $display("FAIL reset_idle_rda got %b exp 0", bus.rda); end
  endtask

  task automatic test_byte();
    send_frame(make_frame(8'hA5, 1'b1, 1'b0), -1);
    idle(20);
    n_checks++; if (bus.rx_data !== 8'hA5) begin n_fail++; $display("FAIL byte_rx_data got %h exp a5", bus.rx_data); end
    n_checks++; if (bus.rda !== 1'b1) begin n_fail++; $display("FAIL byte_rda got %b exp 1", bus.rda); end
    n_checks++; if (bus.framing_err !== 1'b0) begin n_fail++; $display("FAIL byte_fe got %b exp 0", bus.framing_err); end
    bus_cycle(1'b0, 2'd0);
    n_checks++; if (bus.rda !== 1'b1) begin n_fail++; $display("FAIL write_keeps_rda got %b exp 1", bus.rda); end
    bus_cycle(1'b1, 2'd0);
    n_checks++; if (bus.rda !== 1'b0) begin n_fail++; $display("FAIL read_clears_rda got %b exp 0", bus.rda); end
    n_checks++; if (bus.rx_data !== 8'hA5) begin n_fail++; $display("FAIL read_keeps_data got %h exp a5", bus.rx_data); end
  endtask

  task automatic test_false_start();
    @(negedge clk);
    rxd = 1'b0;
    idle(4);
    rxd = 1'b1;
    idle(NBITS * OS + 20);
    n_checks++; if (bus.rda !== 1'b0) begin n_fail++; $display("FAIL false_start_rda got %b exp 0", bus.rda); end
    n_checks++; if (bus.framing_err !== 1'b0) begin n_fail++; $display("FAIL false_start_fe got %b exp 0", bus.framing_err); end
  endtask

  task automatic test_framing();
    send_frame(make_frame(8'h3C, 1'b0, 1'b0), -1);
    idle(32);
    n_checks++; if (bus.framing_err !== 1'b1) begin n_fail++; $display("FAIL framing_fe got %b exp 1", bus.framing_err); end
    n_checks++; if (bus.rda !== 1'b0) begin n_fail++; $display("FAIL framing_rda got %b exp 0", bus.rda); end
    n_checks++; if (bus.rx_data !== 8'hA5) begin n_fail++; $display("FAIL framing_rx_data got %h exp a5", bus.rx_data); end
    bus_cycle(1'b1, 2'd1);
    n_checks++; if (bus.framing_err !== 1'b0) begin n_fail++; $display("FAIL status_clears_fe got %b exp 0", bus.framing_err); end
  endtask

  task automatic test_overrun();
    send_frame(make_frame(8'h11, 1'b1, 1'b0), -1);
    idle(20);
    send_frame(make_frame(8'h22, 1'b1, 1'b0), -1);
    idle(20);
    n_checks++; if (bus.rx_data !== 8'h22) begin n_fail++; $display("FAIL overrun_rx_data got %h exp 22", bus.rx_data); end
    n_checks++; if (bus.overrun_err !== 1'b1) begin n_fail++; $display("FAIL overrun_oe got %b exp 1", bus.overrun_err); end
    n_checks++; if (bus.rda !== 1'b1) begin n_fail++; $display("FAIL overrun_rda got %b exp 1", bus.rda); end
    bus_cycle(1'b1, 2'd1);
    n_checks++; if (bus.overrun_err !== 1'b0) begin n_fail++; $display("FAIL status_clears_oe got %b exp 0", bus.overrun_err); end
    bus_cycle(1'b1, 2'd0);
    n_checks++; if (bus.rda !== 1'b0) begin n_fail++; $display("FAIL overrun_read_rda got %b exp 0", bus.rda); end
  endtask

  task automatic test_read_tie();
    send_frame(make_frame(8'h33, 1'b1, 1'b0), -1);
    idle(20);
    send_frame(make_frame(8'h44, 1'b1, 1'b0), DONE_CYCLE);
    idle(20);
    n_checks++; if (bus.rx_data !== 8'h44) begin n_fail++; $display("FAIL tie_rx_data got %h exp 44", bus.rx_data); end
    n_checks++; if (bus.overrun_err !== 1'b0) begin n_fail++; $display("FAIL tie_oe got %b exp 0", bus.overrun_err); end
    n_checks++; if (bus.rda !== 1'b1) begin n_fail++; $display("FAIL tie_rda got %b exp 1", bus.rda); end
    bus_cycle(1'b1, 2'd0);
  endtask

  task automatic test_parity();
`ifdef UART_RX_PARITY_EN
    send_frame(make_frame(8'h07, 1'b1, 1'b1), -1);
    idle(20);
    n_checks++; if (bus.parity_err !== 1'b1) begin n_fail++; $display("FAIL parity_pe got %b exp 1", bus.parity_err); end
    n_checks++; if (bus.rx_data !== 8'h07) begin n_fail++; $display("FAIL parity_rx_data got %h exp 07", bus.rx_data); end
    n_checks++; if (bus.rda !== 1'b1) begin n_fail++; $display("FAIL parity_rda got %b exp 1", bus.rda); end
    bus_cycle(1'b1, 2'd1);
    n_checks++; if (bus.parity_err !== 1'b0) begin n_fail++; $display("FAIL status_clears_pe got %b exp 0", bus.parity_err); end
`else
    send_frame(make_frame(8'h07, 1'b1, 1'b0), -1);
    idle(20);
    n_checks++; if (bus.parity_err !== 1'b0) begin n_fail++; $display("FAIL parity_tied got %b exp 0", bus.parity_err); end
    n_checks++; if (bus.rx_data !== 8'h07) begin n_fail++; $display("FAIL parity_rx_data got %h exp 07", bus.rx_data); end
`endif
  endtask

  task automatic test_reset_mid_frame();
    bus_cycle(1'b1, 2'd0);
    @(negedge clk);
    rxd = 1'b0;
    idle(50);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    rxd = 1'b1;
    idle(NBITS * OS + 20);
    n_checks++; if (bus.rda !== 1'b0) begin n_fail++; $display("FAIL abort_rda got %b exp 0", bus.rda); end
    n_checks++; if (bus.framing_err !== 1'b0) begin n_fail++; $display("FAIL abort_fe got %b exp 0", bus.framing_err); end
    n_checks++; if (bus.rx_data !== 8'h00) begin n_fail++; $display("FAIL abort_rx_data got %h exp 00", bus.rx_data); end
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    rst        = 1'b0;
    brg_en     = 1'b1;
    rxd        = 1'b1;
    bus.iocs   = 1'b0;
    bus.iorw   = 1'b0;
    bus.ioaddr = 2'd0;
    test_reset();
    test_byte();
    test_false_start();
    test_framing();
    test_overrun();
    test_read_tie();
    test_parity();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
